// File: rtl/daq_uart_pkg.sv
// Shared definitions for the DAQ readback UART: FSM encoding, parity modes and
// frame layout constants.
package daq_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_RELEASE
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic DATA_MARKER = 1'b1;
  localparam int   DATA_BITS   = 8;
  localparam int   WORD_BITS   = DATA_BITS - 1;

endpackage

// File: rtl/daq_uart_tx_if.sv
// Producer-to-transmitter word handshake (four-phase ready/loaded).
interface daq_uart_tx_if;
  import daq_uart_pkg::*;

  logic                 tx_data_ready;
  logic [WORD_BITS-1:0] tx_data;
  logic                 tx_data_loaded;

  modport master (output tx_data_ready, output tx_data, input tx_data_loaded);
  modport slave  (input tx_data_ready, input tx_data, output tx_data_loaded);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses tick on the last clock of each bit, held at 0
// while clear is high.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_MAX);
  assign o_tick = w_wrap && !i_clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_cnt <= '0;
    else if (i_clear || w_wrap) r_cnt <= '0;
    else                       r_cnt <= r_cnt + CNT_W'(1);
  end
endmodule

// File: rtl/daq_uart_tx.sv
// DAQ readback serial transmitter: takes 7-bit words over the ready/loaded
// handshake, prefixes a marker bit and sends one UART frame per word.
module daq_uart_tx
  import daq_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  daq_uart_tx_if.slave   bus,
  output logic           uart_tx,
  output logic           busy
);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e           r_state, w_state;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic [2:0]          r_bit_cnt, w_bit_cnt;
  logic                r_stop_cnt, w_stop_cnt;
  logic                r_par, w_par;
  logic                r_uart_tx, w_uart_tx;
  logic                r_loaded, w_loaded;
  logic                r_busy, w_busy;
  logic                w_tick;
  logic                w_clear;
  logic                w_par_acc;

  assign w_clear   = (r_state == ST_IDLE) || (r_state == ST_RELEASE);
  assign w_par_acc = r_par ^ r_shift[0];

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    w_par      = r_par;
    w_uart_tx  = r_uart_tx;
    w_loaded   = r_loaded;
    w_busy     = r_busy;
    unique case (r_state)
      ST_IDLE: begin
        w_uart_tx = 1'b1;
        w_loaded  = 1'b0;
        w_busy    = 1'b0;
        if (bus.tx_data_ready) begin
          w_shift    = {DATA_MARKER, bus.tx_data};
          w_bit_cnt  = '0;
          w_stop_cnt = 1'b0;
          w_par      = 1'b0;
          w_uart_tx  = 1'b0;
          w_loaded   = 1'b1;
          w_busy     = 1'b1;
          w_state    = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_uart_tx = r_shift[0];
          w_state   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_par = w_par_acc;
          if (r_bit_cnt == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              w_uart_tx = (PARITY == PARITY_ODD) ? ~w_par_acc : w_par_acc;
              w_state   = ST_PAR;
            end else begin
              w_uart_tx = 1'b1;
              w_state   = ST_STOP;
            end
          end else begin
            w_shift   = r_shift >> 1;
            w_uart_tx = r_shift[1];
            w_bit_cnt = r_bit_cnt + 3'd1;
          end
        end
      end
      ST_PAR: begin
        if (w_tick) begin
          w_uart_tx = 1'b1;
          w_state   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_stop_cnt == LAST_STOP) begin
            w_busy = 1'b0;
            // A producer that already dropped ready gets loaded released at the frame end.
            if (!bus.tx_data_ready) begin
              w_loaded = 1'b0;
              w_state  = ST_IDLE;
            end else begin
              w_state  = ST_RELEASE;
            end
          end else begin
            w_stop_cnt = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        w_uart_tx = 1'b1;
        if (!bus.tx_data_ready) begin
          w_loaded = 1'b0;
          w_state  = ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
      r_uart_tx  <= 1'b1;
      r_loaded   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_bit_cnt  <= w_bit_cnt;
      r_stop_cnt <= w_stop_cnt;
      r_par      <= w_par;
      r_uart_tx  <= w_uart_tx;
      r_loaded   <= w_loaded;
      r_busy     <= w_busy;
    end
  end

  assign uart_tx            = r_uart_tx;
  assign busy               = r_busy;
  assign bus.tx_data_loaded = r_loaded;
endmodule

// File: tb/tb_daq_uart_tx.sv
// Bench for daq_uart_tx: default instance plus two short-bit parity instances.
module tb_daq_uart_tx;
  localparam int CPB_A  = 347;
  localparam int CPB_BC = 16;

  logic clk = 1'b0;
  logic rst;
  logic line_a, line_b, line_c;
  logic busy_a, busy_b, busy_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  daq_uart_tx_if if_a ();
  daq_uart_tx_if if_b ();
  daq_uart_tx_if if_c ();

  daq_uart_tx #(.CLKS_PER_BIT(CPB_A), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .bus(if_a), .uart_tx(line_a), .busy(busy_a));
  daq_uart_tx #(.CLKS_PER_BIT(CPB_BC), .PARITY(1), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .bus(if_b), .uart_tx(line_b), .busy(busy_b));
  daq_uart_tx #(.CLKS_PER_BIT(CPB_BC), .PARITY(2), .STOP_BITS(1)) u_c (
    .clk(clk), .rst(rst), .bus(if_c), .uart_tx(line_c), .busy(busy_c));

  typedef struct {
    string       name;
    int          sel;
    logic [6:0]  data;
    int          nbits;
    logic [11:0] exp_bits;  // line bits in send order, bit 0 = start bit
    int          exp_len;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int cpb_of(input int sel);
    return (sel == 0) ? CPB_A : CPB_BC;
  endfunction

  function automatic logic get_line(input int sel);
    case (sel)
      0:       return line_a;
      1:       return line_b;
      default: return line_c;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic get_loaded(input int sel);
    case (sel)
      0:       return if_a.tx_data_loaded;
      1:       return if_b.tx_data_loaded;
      default: return if_c.tx_data_loaded;
    endcase
  endfunction

  task automatic drive(input int sel, input logic rdy, input logic [6:0] d);
    case (sel)
      0:       begin if_a.tx_data_ready = rdy; if_a.tx_data = d; end
      1:       begin if_b.tx_data_ready = rdy; if_b.tx_data = d; end
      default: begin if_c.tx_data_ready = rdy; if_c.tx_data = d; end
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, drop ready 3 cycles after loaded, check every line cycle.
  task automatic run_vec(input vec_t v);
    int cpb, n, bad, hi_ld, hi_busy;
    logic [11:0] got;
    cpb = cpb_of(v.sel);
    drive(v.sel, 1'b1, v.data);
    n = 0;
    while (get_loaded(v.sel) !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    check({v.name, " load"}, 32'(get_loaded(v.sel)), 32'd1);
    if (get_loaded(v.sel) !== 1'b1) begin
      drive(v.sel, 1'b0, 7'h00);
      return;
    end
    got = '0; bad = 0; hi_ld = 0; hi_busy = 0;
    for (int i = 0; i < v.exp_len + 40; i++) begin
      if (i < v.exp_len) begin
        if (get_line(v.sel) !== v.exp_bits[i / cpb]) bad++;
        if (i % cpb == cpb / 2) got[i / cpb] = get_line(v.sel);
      end else if (get_line(v.sel) !== 1'b1) begin
        bad++;
      end
      if (get_loaded(v.sel) === 1'b1) hi_ld++;
      if (get_busy(v.sel) === 1'b1) hi_busy++;
      if (i == 3) drive(v.sel, 1'b0, ~v.data);
      cyc();
    end
    check({v.name, " bits"}, 32'(got), 32'(v.exp_bits));
    check({v.name, " bad line cycles"}, bad, 0);
    check({v.name, " loaded width"}, hi_ld, v.exp_len);
    check({v.name, " busy width"}, hi_busy, v.exp_len);
  endtask

  initial begin
    int n, bad, bad_ld, bad_line, bad_busy;
    logic s1, s2;
    int sent, starts, rx_t, gap, min_gap, tail;
    bit rx_on, seen_busy, gap_open;
    logic [9:0] rx_bits;
    logic [9:0] rx_q[$];

    vecs[0] = '{"a_55", 0, 7'h55, 10, 12'h3AA, 3470};
    vecs[1] = '{"b_7f", 1, 7'h7F, 12, 12'hDFE, 192};
    vecs[2] = '{"b_00", 1, 7'h00, 12, 12'hF00, 192};
    vecs[3] = '{"b_2a", 1, 7'h2A, 12, 12'hD54, 192};
    vecs[4] = '{"c_7f", 2, 7'h7F, 11, 12'h7FE, 176};
    vecs[5] = '{"c_00", 2, 7'h00, 11, 12'h500, 176};

    for (int s = 0; s < 3; s++) drive(s, 1'b0, 7'h00);
    rst = 1'b0;
    repeat (5) cyc();
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst line %0d", s), 32'(get_line(s)), 32'd1);
      check($sformatf("rst loaded %0d", s), 32'(get_loaded(s)), 32'd0);
      check($sformatf("rst busy %0d", s), 32'(get_busy(s)), 32'd0);
    end
    rst = 1'b1;
    bad = 0;
    repeat (20) begin
      cyc();
      for (int s = 0; s < 3; s++)
        if (get_line(s) !== 1'b1 || get_busy(s) !== 1'b0 || get_loaded(s) !== 1'b0) bad++;
    end
    check("idle quiet", bad, 0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Ready held high well past the frame end
    drive(0, 1'b1, 7'h33);
    n = 0;
    while (if_a.tx_data_loaded !== 1'b1 && n < 8) begin cyc(); n++; end
    check("hold load", 32'(if_a.tx_data_loaded), 32'd1);
    n = 0;
    while (busy_a !== 1'b0 && n < 3600) begin cyc(); n++; end
    check("hold busy fall", 32'(busy_a), 32'd0);
    bad_ld = 0; bad_line = 0; bad_busy = 0;
    repeat (500) begin
      cyc();
      if (if_a.tx_data_loaded !== 1'b1) bad_ld++;
      if (line_a !== 1'b1) bad_line++;
      if (busy_a !== 1'b0) bad_busy++;
    end
    check("hold loaded stays", bad_ld, 0);
    check("hold line stays", bad_line, 0);
    check("hold no refire", bad_busy, 0);
    drive(0, 1'b0, 7'h33);
    cyc();
    check("hold loaded fall", 32'(if_a.tx_data_loaded), 32'd0);
    bad = 0;
    repeat (20) begin
      cyc();
      if (line_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    check("hold after quiet", bad, 0);

    // Two-flop producer streaming 14 words
    s1 = 1'b0; s2 = 1'b0; sent = 0; starts = 0; rx_t = 0; rx_on = 0;
    gap = 0; min_gap = 1 << 30; seen_busy = 0; gap_open = 0; tail = 0;
    rx_bits = '0;
    for (int c = 0; c < 60000 && tail < 300; c++) begin
      cyc();
      if (!rx_on && line_a === 1'b0) begin
        rx_on = 1; rx_t = 0; starts++;
      end
      if (rx_on) begin
        if (rx_t % CPB_A == CPB_A / 2) rx_bits[rx_t / CPB_A] = line_a;
        rx_t++;
        if (rx_t == 10 * CPB_A) begin
          rx_on = 0;
          rx_q.push_back(rx_bits);
        end
      end
      if (busy_a === 1'b1) begin
        if (gap_open && gap < min_gap) min_gap = gap;
        gap_open = 0; gap = 0; seen_busy = 1;
      end else if (seen_busy) begin
        gap_open = 1; gap++;
      end
      s2 = s1;
      s1 = if_a.tx_data_loaded;
      if (if_a.tx_data_ready) begin
        if (s2) drive(0, 1'b0, 7'h00);
      end else if (!s2 && sent < 14) begin
        drive(0, 1'b1, 7'(sent));
        sent++;
      end
      if (rx_q.size() >= 14 && !rx_on) tail++;
    end
    check("stream starts", starts, 14);
    check("stream frames", rx_q.size(), 14);
    for (int k = 0; k < 14 && k < rx_q.size(); k++)
      check($sformatf("stream word %0d", k), 32'(rx_q[k]), 32'({2'b11, 7'(k), 1'b0}));
    check("stream gap", 32'(min_gap >= 1 && min_gap < (1 << 30)), 32'd1);

    // Asynchronous reset in the middle of data bit 3
    drive(0, 1'b1, 7'h00);
    n = 0;
    while (if_a.tx_data_loaded !== 1'b1 && n < 8) begin cyc(); n++; end
    check("rst mid load", 32'(if_a.tx_data_loaded), 32'd1);
    for (int i = 0; i < 4 * CPB_A + 100; i++) begin
      if (i == 3) drive(0, 1'b0, 7'h00);
      cyc();
    end
    #3;
    check("rst mid line low", 32'(line_a), 32'd0);
    rst = 1'b0;
    #1;
    check("rst mid line", 32'(line_a), 32'd1);
    check("rst mid loaded", 32'(if_a.tx_data_loaded), 32'd0);
    check("rst mid busy", 32'(busy_a), 32'd0);
    repeat (3) @(posedge clk);
    #4 rst = 1'b1;
    cyc();
    bad = 0;
    repeat (20) begin
      cyc();
      if (line_a !== 1'b1 || busy_a !== 1'b0 || if_a.tx_data_loaded !== 1'b0) bad++;
    end
    check("rst mid quiet", bad, 0);
    run_vec('{"a_2a_after_rst", 0, 7'h2A, 10, 12'h354, 3470});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/daq_uart_tx.md
# daq_uart_tx

Serial transmitter for the DAQ readback path. Consumes 7-bit words from a readback/DAQ producer over the `tx_data_ready` / `tx_data_loaded` four-phase handshake. Prefixes each word with a leading-1 data-marker bit and shifts it out as an asynchronous UART frame on the host link. Runs on the 40 MHz system clock, the same clock as the producer, so no handshake synchronisers are needed inside this block.

## Interface
- `CLKS_PER_BIT`, 347, system clocks per serial bit (40 MHz / 115200 baud); legal range 2..65535
- `PARITY`, 0, parity mode: 0 = none, 1 = even, 2 = odd
- `STOP_BITS`, 1, number of stop bits: 1 or 2

- `clk`  in  1  system clock, 40 MHz; all logic on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `tx_data_ready`  in  1  producer has a valid word on `tx_data`
- `tx_data`  in  7  data word; sampled only at the load cycle
- `tx_data_loaded`  out  1  word accepted; held high until the frame is sent and `tx_data_ready` is low
- `uart_tx`  out  1  serial line; idles high
- `busy`  out  1  high from the load cycle to the end of the last stop bit

## Operation
- States: IDLE, START, DATA, PAR, STOP, RELEASE.
- IDLE
  - `uart_tx`=1, `tx_data_loaded`=0.
  - When `tx_data_ready`=1: latch shift register ← {1'b1, `tx_data`}, set `tx_data_loaded`=1 and `busy`=1, go to START.
- START: `uart_tx`=0 for one bit time.
- DATA
  - 8 bits, LSB first: `tx_data[0]`..`tx_data[6]`, then the marker bit 1.
  - 3-bit bit counter.
- PAR
  - Entered only when `PARITY`≠0; otherwise skipped.
  - Even mode: XOR of the 8 transmitted bits. Odd mode: its inverse.
- STOP
  - `uart_tx`=1 for `STOP_BITS` bit times.
  - At the end of the last stop bit: `busy`=0, go to RELEASE.
- RELEASE
  - `uart_tx`=1, `tx_data_loaded` stays 1.
  - On the first cycle `tx_data_ready`=0 is sampled: `tx_data_loaded`←0, go to IDLE.
  - A `tx_data_ready` held high never causes a duplicate frame.
- Bit timer
  - Counts 0..`CLKS_PER_BIT`-1, width $clog2(`CLKS_PER_BIT`).
  - Reloads at each bit boundary; held at 0 in IDLE and RELEASE.
- Changes on `tx_data` after the load cycle are ignored.
- `tx_data_ready` dropping mid-frame does not abort the frame.
- Reset (`rst`=0, any state, including mid-frame)
  - Immediately: state IDLE, `uart_tx`=1, `tx_data_loaded`=0, `busy`=0, counters 0.
  - The partial frame is abandoned with no glitch low.
- All outputs are registered.

## Timing
- Load latency: `tx_data_ready` sampled high in IDLE at edge N → `tx_data_loaded`=1, `busy`=1 and `uart_tx`=0 after edge N.
- Every bit, start bit included, is exactly `CLKS_PER_BIT` cycles.
- Frame length F = (1+8+(`PARITY`≠0)+`STOP_BITS`)·`CLKS_PER_BIT` cycles; default F = 3470.
- `busy` falls after edge N+F.
- `tx_data_loaded` falls at the first edge ≥ N+F at which `tx_data_ready`=0.
- With a producer that has already dropped ready:
  - `tx_data_loaded` falls at N+F.
  - Earliest next load is N+F+1, so the line stays idle-high for at least one cycle.
- Producer compatibility: a producer that registers `tx_data_loaded` through two flops sees the high level within 2 cycles. It drops ready long before F for any `CLKS_PER_BIT`≥2.

## Structure
- Shared package/include `daq_uart_pkg`:
  - state encoding
  - PARITY_NONE/EVEN/ODD constants
  - DATA_MARKER = 1'b1
  - DATA_BITS = 8
- One sub-module, `uart_baud_tick`: parameterised bit-period counter with `clear` input and `tick` output. It is reusable by the future UART receiver.
- Everything else (FSM, shift register, parity accumulator) stays in `daq_uart_tx`.

## Test plan
- Reset: hold `rst`=0 for 5 cycles → `uart_tx`=1, `tx_data_loaded`=0, `busy`=0; no activity with `tx_data_ready`=0.
- Single word 0x55, defaults, producer drops ready 3 cycles after loaded → line bits 0,1,0,1,0,1,0,1,1,1, each 347 cycles wide. `tx_data_loaded` high for exactly 3470 cycles.
- Producer model (two-flop loaded sync, 14 words 0x00..0x0D) → 14 frames decoded in order, no duplicates. Idle gap between frames ≥ 1 cycle.
- Ready held high 500 cycles past frame end → `tx_data_loaded` stays 1 and `uart_tx` stays 1 throughout. No second frame until ready low, then loaded falls on the next edge.
- `PARITY`=1, `STOP_BITS`=2, word 0x7F → 8 ones, parity bit 0, two stop bits. `PARITY`=2 on the same word → parity bit 1.
- Assert `rst`=0 mid DATA bit 3, asynchronously between edges → `uart_tx`=1 and `tx_data_loaded`=0 immediately. After release, word 0x2A transmits correctly.
